// File: rtl/result_bus_scheduler.sv
// result_bus_scheduler
//
// Round-robin arbiter that shares BUS_COUNT result broadcast buses among
// STATION_COUNT producing stations. Each cycle up to BUS_COUNT ready stations
// are granted, scanning from a rotating priority pointer; the granted results
// are driven onto the buses from registers one cycle later.
//
// Ports
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   flush          synchronous flush: no grants this cycle, buses and pointer
//                  clear at the next edge
//   station_ready  per-station request (must come from station registers)
//   station_value  per-station result value, valid while ready is high
//   station_grant  per-station combinational grant for the current cycle
//   bus_asserted   per-bus registered valid
//   bus_source     per-bus registered index of the producing station
//   bus_value      per-bus registered broadcast value
module result_bus_scheduler #(
  parameter int SIZE          = 32,
  parameter int STATION_COUNT = 4,
  parameter int BUS_COUNT     = 2,
  localparam int STATION_INDEX_SIZE = $clog2(STATION_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          flush,
  input  logic                          station_ready [0:STATION_COUNT-1],
  input  logic [SIZE-1:0]               station_value [0:STATION_COUNT-1],
  output logic                          station_grant [0:STATION_COUNT-1],
  output logic                          bus_asserted  [0:BUS_COUNT-1],
  output logic [STATION_INDEX_SIZE-1:0] bus_source    [0:BUS_COUNT-1],
  output logic [SIZE-1:0]               bus_value     [0:BUS_COUNT-1]
);

  localparam int SW = STATION_INDEX_SIZE;

  logic [SW-1:0]   ptr;
  logic            sel_vld_p0 [0:BUS_COUNT-1];
  logic [SW-1:0]   sel_src_p0 [0:BUS_COUNT-1];
  logic [SIZE-1:0] sel_val_p0 [0:BUS_COUNT-1];
  logic            any_p0;
  logic [SW-1:0]   last_p0;
  logic [SW-1:0]   ptr_nxt_p0;

  // Stage p0: combinational grant selection.
  // Bus k takes the first ready station (in rotated order from ptr) not yet
  // claimed by a lower-numbered bus, so bus k ends up with the k-th ready
  // station found. The rotated position is reduced modulo STATION_COUNT so
  // non-power-of-two station counts wrap correctly.
  always_comb begin : grant_scan
    logic          req   [0:STATION_COUNT-1];
    logic          taken [0:STATION_COUNT-1];
    logic [SW:0]   pos;
    logic [SW-1:0] idx;
    logic          found;

    pos     = '0;
    idx     = '0;
    found   = 1'b0;
    any_p0  = 1'b0;
    last_p0 = '0;
    for (int i = 0; i < STATION_COUNT; i++) begin
      // Flush and reset both suppress every request, hence every grant.
      req[i]   = station_ready[i] & ~flush & reset_n;
      taken[i] = 1'b0;
    end
    for (int k = 0; k < BUS_COUNT; k++) begin
      sel_vld_p0[k] = 1'b0;
      sel_src_p0[k] = '0;
      sel_val_p0[k] = '0;
    end

    for (int k = 0; k < BUS_COUNT; k++) begin
      found = 1'b0;
      for (int i = 0; i < STATION_COUNT; i++) begin
        pos = {1'b0, ptr} + (SW+1)'(i);
        if (pos >= (SW+1)'(STATION_COUNT)) begin
          pos = pos - (SW+1)'(STATION_COUNT);
        end
        idx = pos[SW-1:0];
        if (!found && req[idx] && !taken[idx]) begin
          found         = 1'b1;
          taken[idx]    = 1'b1;
          sel_vld_p0[k] = 1'b1;
          sel_src_p0[k] = idx;
          sel_val_p0[k] = station_value[idx];
          any_p0        = 1'b1;
          last_p0       = idx;
        end
      end
    end

    for (int i = 0; i < STATION_COUNT; i++) begin
      station_grant[i] = taken[i];
    end
  end

  // Next pointer starts just past the last station granted this cycle.
  assign ptr_nxt_p0 = (last_p0 == SW'(STATION_COUNT - 1)) ? '0 : last_p0 + 1'b1;

  // Stage p1: bus registers and pointer. Buses reload every cycle, so a
  // result is asserted for exactly one cycle per grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      for (int k = 0; k < BUS_COUNT; k++) begin
        bus_asserted[k] <= 1'b0;
        bus_source[k]   <= '0;
        bus_value[k]    <= '0;
      end
    end else if (flush) begin
      ptr <= '0;
      for (int k = 0; k < BUS_COUNT; k++) begin
        bus_asserted[k] <= 1'b0;
        bus_source[k]   <= '0;
        bus_value[k]    <= '0;
      end
    end else begin
      if (any_p0) begin
        ptr <= ptr_nxt_p0;
      end
      for (int k = 0; k < BUS_COUNT; k++) begin
        bus_asserted[k] <= sel_vld_p0[k];
        bus_source[k]   <= sel_src_p0[k];
        bus_value[k]    <= sel_val_p0[k];
      end
    end
  end

endmodule

// File: tb/tb_result_bus_scheduler.sv
module tb_result_bus_scheduler;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        station_ready [0:3];
  logic [31:0] station_value [0:3];
  logic        station_grant [0:3];
  logic        bus_asserted  [0:1];
  logic [1:0]  bus_source    [0:1];
  logic [31:0] bus_value     [0:1];

  result_bus_scheduler #(
    .SIZE(32),
    .STATION_COUNT(4),
    .BUS_COUNT(2)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .station_ready(station_ready),
    .station_value(station_value),
    .station_grant(station_grant),
    .bus_asserted(bus_asserted),
    .bus_source(bus_source),
    .bus_value(bus_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit have_pend = 1'b0;
  logic [31:0] vbase;

  typedef struct {
    string       tag;
    logic [3:0]  g;
    logic [1:0]  a;
    logic [1:0]  s0;
    logic [1:0]  s1;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] gmask();
    return {station_grant[3], station_grant[2], station_grant[1], station_grant[0]};
  endfunction

  task automatic drive(input logic [3:0] rdy, input logic fl, input logic [31:0] base);
    for (int i = 0; i < 4; i++) begin
      station_ready[i] = rdy[i];
      station_value[i] = base + 32'(i);
    end
    flush = fl;
  endtask

  // One cycle of stimulus; expectation covers this cycle's grants and the
  // bus contents after the following edge.
  task automatic step(input string tag, input logic [3:0] rdy, input logic fl,
                      input logic [3:0] eg, input logic [1:0] ea,
                      input logic [1:0] es0, input logic [1:0] es1,
                      input logic [31:0] ev0, input logic [31:0] ev1);
    exp_t e;
    @(posedge clock);
    #1;
    drive(rdy, fl, vbase);
    e.tag = tag; e.g = eg; e.a = ea;
    e.s0 = es0; e.s1 = es1; e.v0 = ev0; e.v1 = ev1;
    q.push_back(e);
  endtask

  // Monitor: grants checked mid-cycle, buses checked one cycle later.
  initial begin
    exp_t cur;
    exp_t pend;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        if (have_pend) begin
          chk($sformatf("%s bus0_asserted", pend.tag), 32'(bus_asserted[0]), 32'(pend.a[0]));
          chk($sformatf("%s bus1_asserted", pend.tag), 32'(bus_asserted[1]), 32'(pend.a[1]));
          chk($sformatf("%s bus0_source", pend.tag), 32'(bus_source[0]), 32'(pend.s0));
          chk($sformatf("%s bus1_source", pend.tag), 32'(bus_source[1]), 32'(pend.s1));
          chk($sformatf("%s bus0_value", pend.tag), bus_value[0], pend.v0);
          chk($sformatf("%s bus1_value", pend.tag), bus_value[1], pend.v1);
          have_pend = 1'b0;
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
          chk($sformatf("%s grant", cur.tag), 32'(gmask()), 32'(cur.g));
          pend = cur;
          have_pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vbase   = 32'hA0;
    reset_n = 1'b0;
    drive(4'b1111, 1'b0, vbase);

    // Reset held with all stations ready.
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hold grant", 32'(gmask()), 32'h0);
    chk("reset_hold bus0_asserted", 32'(bus_asserted[0]), 32'h0);
    chk("reset_hold bus1_asserted", 32'(bus_asserted[1]), 32'h0);
    chk("reset_hold bus0_value", bus_value[0], 32'h0);

    // Release, one live cycle, then reset asserted between edges.
    reset_n = 1'b1;
    #1;
    chk("release grant", 32'(gmask()), 32'b0011);
    @(posedge clock);
    #1;
    chk("live bus0_asserted", 32'(bus_asserted[0]), 32'h1);
    chk("live bus1_value", bus_value[1], 32'hA1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset grant", 32'(gmask()), 32'h0);
    chk("async_reset bus0_asserted", 32'(bus_asserted[0]), 32'h0);
    chk("async_reset bus1_asserted", 32'(bus_asserted[1]), 32'h0);
    chk("async_reset bus0_source", 32'(bus_source[0]), 32'h0);
    chk("async_reset bus1_source", 32'(bus_source[1]), 32'h0);
    chk("async_reset bus0_value", bus_value[0], 32'h0);
    chk("async_reset bus1_value", bus_value[1], 32'h0);
    drive(4'b0000, 1'b0, vbase);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("idle_after_reset bus0_asserted", 32'(bus_asserted[0]), 32'h0);
    chk("idle_after_reset bus1_asserted", 32'(bus_asserted[1]), 32'h0);

    mon_en = 1'b1;
    //   tag             ready    fl    grant    asrt   s0 s1  v0            v1
    step("burst0",       4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1, 32'hA0,       32'hA1);
    step("burst1",       4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3, 32'hA2,       32'hA3);
    step("fair2",        4'b1111, 1'b0, 4'b0011, 2'b11, 0, 1, 32'hA0,       32'hA1);
    step("fair3",        4'b1111, 1'b0, 4'b1100, 2'b11, 2, 3, 32'hA2,       32'hA3);
    step("wrap_setup",   4'b0011, 1'b0, 4'b0011, 2'b11, 0, 1, 32'hA0,       32'hA1);
    step("wrap",         4'b1000, 1'b0, 4'b1000, 2'b01, 3, 0, 32'hA3,       32'h0);
    step("wrap_ptr",     4'b1001, 1'b0, 4'b1001, 2'b11, 0, 3, 32'hA0,       32'hA3);
    step("sparse_setup", 4'b0001, 1'b0, 4'b0001, 2'b01, 0, 0, 32'hA0,       32'h0);
    step("sparse",       4'b0101, 1'b0, 4'b0101, 2'b11, 2, 0, 32'hA2,       32'hA0);
    step("sparse_ptr",   4'b0011, 1'b0, 4'b0011, 2'b11, 1, 0, 32'hA1,       32'hA0);
    step("flush",        4'b0110, 1'b1, 4'b0000, 2'b00, 0, 0, 32'h0,        32'h0);
    step("post_flush",   4'b1001, 1'b0, 4'b1001, 2'b11, 0, 3, 32'hA0,       32'hA3);
    vbase = 32'h1234_5670;
    step("value",        4'b0100, 1'b0, 4'b0100, 2'b01, 2, 0, 32'h12345672, 32'h0);
    step("rot3",         4'b1111, 1'b0, 4'b1001, 2'b11, 3, 0, 32'h12345673, 32'h12345670);
    step("idle",         4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0, 32'h0,        32'h0);
    step("idle_ptr",     4'b1110, 1'b0, 4'b0110, 2'b11, 1, 2, 32'h12345671, 32'h12345672);
    step("tail",         4'b0000, 1'b0, 4'b0000, 2'b00, 0, 0, 32'h0,        32'h0);

    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0 && !have_pend) break;
      @(posedge clock);
    end
    if (q.size() != 0 || have_pend) begin
      errors++;
      $display("FAIL drain actual=pending expected=empty");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
